// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Brief    : Shared types, widths and helpers for the APB round-robin master.
// Revision : 1.0
// ============================================================================
package apb_pkg;

   typedef enum logic [1:0] {
      APB_IDLE   = 2'd0,
      APB_SETUP  = 2'd1,
      APB_ACCESS = 2'd2
   } apb_state_e;

   localparam int APB_ADDR_W = 8;
   localparam int APB_DATA_W = 8;

   // Minimum bits needed to count 0..value-1; never narrower than 1 bit.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first request at or after ptr.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
   parameter int N  = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_idx
);

   always_comb begin
      logic [PW-1:0] w_idx;
      logic          w_found;
      grant     = '0;
      grant_idx = '0;
      w_found   = 1'b0;
      w_idx     = ptr;
      for (int k = 0; k < N; k++) begin
         if (en && !w_found && req[w_idx]) begin
            grant[w_idx] = 1'b1;
            grant_idx    = w_idx;
            w_found      = 1'b1;
         end
         w_idx = (w_idx == PW'(N - 1)) ? '0 : w_idx + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/apb_rr_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_rr_master
// Brief    : Shares one APB bus among NUM_REQ requesters, round-robin, with
//            wait-state handling and a pready timeout.
// Revision : 1.0
// ============================================================================
module apb_rr_master
   import apb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic                        pclk,
   input  logic                        prst,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ-1:0]          req_write,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]           rsp_rdata,
   output logic                        rsp_err,
   output logic [ADDR_W-1:0]           paddr,
   output logic                        pwrite,
   output logic                        psel,
   output logic                        pen,
   output logic [DATA_W-1:0]           pwdata,
   input  logic [DATA_W-1:0]           prdata,
   input  logic                        pready
);

   localparam int c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int c_cnt_w = clog2(TIMEOUT);

   apb_state_e           r_state;
   logic [c_idx_w-1:0]   r_ptr;
   logic [c_idx_w-1:0]   r_owner;
   logic                 r_write;
   logic [ADDR_W-1:0]    r_addr;
   logic [DATA_W-1:0]    r_wdata;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [NUM_REQ-1:0]   r_rsp_valid;
   logic [DATA_W-1:0]    r_rsp_rdata;
   logic                 r_rsp_err;

   logic                 w_arb_en;
   logic                 w_accept;
   logic [c_idx_w-1:0]   w_gidx;
   logic                 w_sel_write;
   logic [ADDR_W-1:0]    w_sel_addr;
   logic [DATA_W-1:0]    w_sel_wdata;

   // Grants are offered only while idle and out of reset.
   assign w_arb_en = (r_state == APB_IDLE) && !prst;
   assign w_accept = |req_ready;

   rr_arbiter #(
      .N  (NUM_REQ),
      .PW (c_idx_w)
   ) u_arb (
      .req       (req_valid),
      .ptr       (r_ptr),
      .en        (w_arb_en),
      .grant     (req_ready),
      .grant_idx (w_gidx)
   );

   always_comb begin
      w_sel_write = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gidx == c_idx_w'(i)) begin
            w_sel_write = req_write[i];
            w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (prst) begin
         r_state     <= APB_IDLE;
         r_ptr       <= '0;
         r_owner     <= '0;
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cnt       <= '0;
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= '0;
         case (r_state)
            APB_IDLE: begin
               if (w_accept) begin
                  r_write <= w_sel_write;
                  r_addr  <= w_sel_addr;
                  r_wdata <= w_sel_wdata;
                  r_owner <= w_gidx;
                  r_ptr   <= (w_gidx == c_idx_w'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
                  r_state <= APB_SETUP;
               end
            end
            APB_SETUP: begin
               r_cnt   <= '0;
               r_state <= APB_ACCESS;
            end
            APB_ACCESS: begin
               if (pready) begin
                  r_rsp_valid[r_owner] <= 1'b1;
                  r_rsp_rdata          <= r_write ? '0 : prdata;
                  r_rsp_err            <= 1'b0;
                  r_state              <= APB_IDLE;
               end else if (r_cnt == c_cnt_w'(TIMEOUT - 1)) begin
                  r_rsp_valid[r_owner] <= 1'b1;
                  r_rsp_rdata          <= '0;
                  r_rsp_err            <= 1'b1;
                  r_state              <= APB_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= APB_IDLE;
         endcase
      end
   end

   assign psel      = (r_state != APB_IDLE);
   assign pen       = (r_state == APB_ACCESS);
   assign paddr     = r_addr;
   assign pwrite    = r_write;
   assign pwdata    = r_wdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_rr_master
// Brief    : Scoreboard bench for apb_rr_master (2 requesters, TIMEOUT=16).
// Revision : 1.0
// ============================================================================
module tb_apb_rr_master;

   logic        pclk = 1'b0;
   logic        prst;
   logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
   logic [15:0] req_addr, req_wdata;
   logic [7:0]  rsp_rdata, paddr, pwdata, prdata;
   logic        rsp_err, pwrite, psel, pen, pready;

   always #5 pclk = ~pclk;

   apb_rr_master #(
      .NUM_REQ (2),
      .ADDR_W  (8),
      .DATA_W  (8),
      .TIMEOUT (16)
   ) dut (
      .pclk      (pclk),
      .prst      (prst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .paddr     (paddr),
      .pwrite    (pwrite),
      .psel      (psel),
      .pen       (pen),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready)
   );

   typedef struct packed {
      logic [1:0] oh;
      logic [7:0] rdata;
      logic       err;
   } exp_t;

   exp_t       sb[$];
   int         order[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         mptr = 0, acc_cnt = 0, wait_cfg = 0;
   int         pen_run = 0, last_pen_len = 0, idle_run = 0, pidx = 0;
   bit         stuck = 0, idle_high = 0, hold = 0, pending = 0;
   logic [7:0] rd_val = 8'h00, cur_addr = 8'h00, cur_wdata = 8'h00;
   logic       cur_write = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] rr_pick(input logic [1:0] v, input int p);
      rr_pick = 2'b00;
      if (p == 0) begin
         if (v[0]) rr_pick = 2'b01;
         else if (v[1]) rr_pick = 2'b10;
      end else begin
         if (v[1]) rr_pick = 2'b10;
         else if (v[0]) rr_pick = 2'b01;
      end
   endfunction

   // One bus cycle: called just after a negedge with inputs set for this cycle.
   task automatic tick();
      logic [1:0] expg;
      exp_t       e;
      #1;
      if (prst) begin
         mptr = 0;
      end else begin
         expg = psel ? 2'b00 : rr_pick(req_valid, mptr);
         check("req_ready", 32'(req_ready), 32'(expg));
         if (expg != 2'b00) begin
            pidx      = expg[1] ? 1 : 0;
            pending   = 1;
            order.push_back(pidx);
            mptr      = (pidx + 1) % 2;
            cur_addr  = pidx ? req_addr[15:8]  : req_addr[7:0];
            cur_wdata = pidx ? req_wdata[15:8] : req_wdata[7:0];
            cur_write = req_write[pidx];
            e.oh      = expg;
            e.err     = stuck;
            e.rdata   = (stuck || cur_write) ? 8'h00 : rd_val;
            sb.push_back(e);
         end
      end
      if (pen === 1'b1) begin
         acc_cnt++;
         check("stable", 32'({paddr, pwrite, pwdata}), 32'({cur_addr, cur_write, cur_wdata}));
      end else begin
         acc_cnt = 0;
      end
      pready = stuck ? 1'b0 : ((pen === 1'b1) ? (acc_cnt > wait_cfg) : idle_high);
      prdata = rd_val;
      @(posedge pclk);
      @(negedge pclk);
      if (pending) begin
         if (!hold) req_valid[pidx] = 1'b0;
         pending = 0;
      end
      if (|rsp_valid) begin
         if (sb.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            check("rsp_owner", 32'(rsp_valid), 32'(e.oh));
            check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
            check("rsp_err",   32'(rsp_err),   32'(e.err));
         end
      end
      if (pen === 1'b1) pen_run++;
      else if (pen_run > 0) begin
         last_pen_len = pen_run;
         pen_run      = 0;
      end
      if (psel !== 1'b1) idle_run++;
      else if (idle_run > 0) begin
         if (hold && order.size() > 1) check("idle_gap", 32'(idle_run), 32'd1);
         idle_run = 0;
      end
   endtask

   task automatic drain(input string tag, input int budget);
      for (int i = 0; i < budget && (sb.size() != 0 || req_valid != 2'b00); i++) tick();
      check(tag, 32'(sb.size() + int'(req_valid != 2'b00)), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      prst      = 1'b1;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      pready    = 1'b0;
      prdata    = '0;
      @(negedge pclk);
      tick();
      tick();
      check("rst_bus",   32'({psel, pen, pwrite, paddr, pwdata}), 32'd0);
      check("rst_rsp",   32'({rsp_valid, rsp_rdata, rsp_err}), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      prst = 1'b0;

      // Single write, pready tied high (also high in IDLE/SETUP)
      idle_high = 1; wait_cfg = 0;
      req_write[0] = 1'b1; req_addr[7:0] = 8'h12; req_wdata[7:0] = 8'hA5;
      req_valid = 2'b01;
      tick();
      check("wr_setup", 32'({psel, pen}), 32'b10);
      check("wr_no_early1", 32'(sb.size()), 32'd1);
      tick();
      check("wr_access", 32'({psel, pen, paddr, pwdata, pwrite}), 32'({2'b11, 8'h12, 8'hA5, 1'b1}));
      check("wr_no_early2", 32'(sb.size()), 32'd1);
      tick();
      check("wr_rsp_cycle3", 32'(sb.size()), 32'd0);

      // Read with 3 wait states; address changes after accept must not matter
      idle_high = 0; wait_cfg = 3; rd_val = 8'h3C;
      req_write[1] = 1'b0; req_addr[15:8] = 8'h40; req_wdata[15:8] = 8'h99;
      req_valid = 2'b10;
      tick();
      req_addr[15:8] = 8'hEE;
      drain("rd_drain", 30);
      check("rd_pen_len", 32'(last_pen_len), 32'd4);
      check("rd_data", 32'(rsp_rdata), 32'h3C);

      // Contention, both valid continuously
      wait_cfg = 0; rd_val = 8'h5A; hold = 1;
      order.delete();
      req_write = 2'b01; req_addr = 16'h3020; req_wdata = 16'h7711;
      req_valid = 2'b11;
      for (int i = 0; i < 40 && order.size() < 4; i++) tick();
      check("cont_count", 32'(order.size()), 32'd4);
      for (int k = 0; k < order.size(); k++) check("cont_order", 32'(order[k]), 32'(k % 2));
      hold = 0; req_valid = 2'b00;
      drain("cont_drain", 30);

      // Timeout
      stuck = 1; rd_val = 8'h77;
      req_write[0] = 1'b0; req_addr[7:0] = 8'h55;
      req_valid = 2'b01;
      drain("to_drain", 60);
      check("to_pen_len", 32'(last_pen_len), 32'd16);
      check("to_rsp", 32'({rsp_err, rsp_rdata}), 32'({1'b1, 8'h00}));
      check("to_idle", 32'({psel, pen}), 32'd0);

      // Reset in ACCESS cycle 2
      req_write[1] = 1'b0; req_addr[15:8] = 8'h66;
      req_valid = 2'b10;
      for (int i = 0; i < 10 && pen !== 1'b1; i++) tick();
      tick();
      check("pre_rst_access", 32'(pen), 32'd1);
      prst = 1'b1;
      tick();
      check("rst_mid_bus", 32'({psel, pen}), 32'd0);
      check("rst_mid_rsp", 32'(rsp_valid), 32'd0);
      prst = 1'b0; stuck = 0; wait_cfg = 0;
      sb.delete(); order.delete(); pen_run = 0;
      req_valid = 2'b11;
      tick();
      check("rst_first_winner", 32'(order.size() > 0 ? order[0] : 9), 32'd0);
      drain("rst_drain", 40);

      // pready high in IDLE/SETUP with two wait states
      idle_high = 1; wait_cfg = 2; rd_val = 8'hC3;
      req_write[0] = 1'b0; req_addr[7:0] = 8'h7E;
      req_valid = 2'b01;
      tick();
      tick();
      check("setup_ignore", 32'(sb.size()), 32'd1);
      drain("ws_drain", 30);
      check("ws_pen_len", 32'(last_pen_len), 32'd3);
      check("ws_data", 32'(rsp_rdata), 32'hC3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
